tournament_selection: RTL and testbench
=======================================

# tournament_selection

Parametrised tournament-selection unit for the genetic-algorithm datapath. It accepts a stream of TOUR_SIZE candidates, each a signed fitness value plus a population index, over a valid/ready handshake. It then presents the winning candidate's index and fitness on an output valid/ready handshake. It sits between the fitness-evaluation stage and the crossover stage, and generalises the two-way registered comparator to K-way tournaments with selectable minimise/maximise objective and flush.

## Interface
- FIT_W, 27, fitness width; two's-complement signed.
- IDX_W, 8, population index width.
- TOUR_SIZE, 4, candidates per tournament; legal range 2..256.
- MAXIMIZE, 0, 0 = lower fitness wins, 1 = higher fitness wins.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- flush  input  1  abandons the current tournament.
- in_valid  input  1  candidate present.
- in_ready  output  1  unit can accept a candidate.
- in_fitness  input  FIT_W  candidate fitness, signed.
- in_index  input  IDX_W  candidate population index.
- out_valid  output  1  winner available.
- out_ready  input  1  consumer accepts winner.
- out_index  output  IDX_W  winner index.
- out_fitness  output  FIT_W  winner fitness, signed.
- busy  output  1  at least one candidate of the current tournament accepted, or result pending.

## Operation
- States:
  - COLLECT: in_ready=1, out_valid=0.
  - RESULT: in_ready=0, out_valid=1.
- Candidate counter cnt counts 0..TOUR_SIZE-1 and is $clog2(TOUR_SIZE) bits wide, with a minimum of 1 bit.
- Accept means in_valid && in_ready on a rising edge.
- When cnt==0 and a candidate is accepted, it is loaded unconditionally into best_fitness/best_index.
- When cnt>0 and a candidate is accepted, it replaces best under these rules:
  - MAXIMIZE=0: replace if in_fitness <= best_fitness.
  - MAXIMIZE=1: replace if in_fitness >= best_fitness.
  - Ties always go to the later-arriving candidate.
- Comparison is full-width signed; no saturation or truncation.
- Accepting the candidate with cnt==TOUR_SIZE-1 transitions to RESULT and resets cnt to 0. The best register includes that final candidate.
- In RESULT, the outputs hold stable while out_ready=0. When out_valid && out_ready, the unit returns to COLLECT.
- out_index/out_fitness are driven directly from the best registers.
- flush=1 in either state, on the next edge:
  - returns the FSM to COLLECT, with cnt=0 and busy=0;
  - any pending result is discarded;
  - any candidate presented in the same cycle is not accepted.
- flush has priority over accept and over the output handshake.
- rst_n=0 has priority over flush.
- busy = (cnt!=0) || (state==RESULT).

## Timing
- Reset (rst_n low at an edge): state=COLLECT, cnt=0, best_fitness=0, best_index=0, out_valid=0, busy=0.
  - in_ready reads 1 once reset is released; in_ready=0 while rst_n=0.
- Accept rate: one candidate per cycle while in_valid stays high.
- Latency: out_valid rises the cycle after the edge that accepted the TOUR_SIZE-th candidate.
- Throughput: one tournament per TOUR_SIZE+1 cycles at best. There is no accept during RESULT, including in the out_ready cycle.
- in_valid gaps simply pause collection; cnt and best hold.
- Reset asserted mid-tournament or mid-RESULT discards all state at that edge.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with in_valid=1, then release.
  - During reset: out_valid=0, busy=0, in_ready=0, no accept.
  - First cycle after release: in_ready=1.
- Minimise, TOUR_SIZE=4: fitnesses {50, -7, 12, 3} with indices {10, 11, 12, 13}, back to back.
  - One cycle after the 4th accept: out_valid=1, out_index=11, out_fitness=-7.
- Tie and backpressure: fitnesses {5, 5, 9, 5} with indices {1, 2, 3, 4}, out_ready=0 for 5 cycles.
  - out_index=4 and out_fitness=5, held stable throughout.
  - in_ready=0 throughout.
  - out_ready pulse -> COLLECT next cycle.
- MAXIMIZE=1, FIT_W=27: fitnesses {-2^26, 2^26-1, 0, -1} with indices {0, 1, 2, 3}.
  - out_index=1, out_fitness=2^26-1, confirming signed extremes.
- Flush: accept 2 candidates, assert flush together with in_valid.
  - Next cycle: busy=0, and that candidate is not counted.
  - Then {7, 8, 9, 6} with indices {20, 21, 22, 23} -> out_index=23 (minimise).
  - Flush during RESULT drops out_valid the next cycle.
- Gapped input: 4 candidates with random 0-3 cycle in_valid gaps, checked against a software min/max model over 1000 tournaments, including back-to-back out_ready=1 operation.

Source files
------------

// File: rtl/tournament_selection.sv
// K-way tournament selector: collects TOUR_SIZE (fitness, index) candidates and
// presents the best one on an output handshake; ties go to the later arrival.
module tournament_selection #(
  parameter int FIT_W     = 27,
  parameter int IDX_W     = 8,
  parameter int TOUR_SIZE = 4,
  parameter bit MAXIMIZE  = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [FIT_W-1:0] in_fitness,
  input  logic        [IDX_W-1:0] in_index,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic        [IDX_W-1:0] out_index,
  output logic signed [FIT_W-1:0] out_fitness,
  output logic                    busy
);

  localparam int CNT_W = (TOUR_SIZE > 2) ? $clog2(TOUR_SIZE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOUR_SIZE - 1);

  typedef enum logic {COLLECT = 1'b0, RESULT = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [FIT_W-1:0] best_fit_q, best_fit_d;
  logic [IDX_W-1:0]        best_idx_q, best_idx_d;
  logic                    accept;

  // Non-strict compare so an equal later candidate takes over the best slot.
  function automatic logic wins(input logic signed [FIT_W-1:0] cand,
                                input logic signed [FIT_W-1:0] best);
    if (MAXIMIZE) return cand >= best;
    else          return cand <= best;
  endfunction

  assign in_ready    = (state_q == COLLECT) && rst_n;
  assign out_valid   = (state_q == RESULT);
  assign busy        = (cnt_q != '0) || (state_q == RESULT);
  assign out_index   = best_idx_q;
  assign out_fitness = best_fit_q;
  assign accept      = in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    best_fit_d = best_fit_q;
    best_idx_d = best_idx_q;
    if (flush) begin
      state_d = COLLECT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (accept) begin
            if ((cnt_q == '0) || wins(in_fitness, best_fit_q)) begin
              best_fit_d = in_fitness;
              best_idx_d = in_index;
            end
            if (cnt_q == LAST) begin
              cnt_d   = '0;
              state_d = RESULT;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        RESULT: begin
          if (out_ready) state_d = COLLECT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= COLLECT;
      cnt_q      <= '0;
      best_fit_q <= '0;
      best_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      best_fit_q <= best_fit_d;
      best_idx_q <= best_idx_d;
    end
  end

endmodule

// File: tb/tb_tournament_selection.sv
// Bench for tournament_selection: a minimise and a maximise instance share one
// stimulus stream and are checked every cycle against a queue-based model.
module tb_tournament_selection;

  localparam int FW = 27;
  localparam int IW = 8;
  localparam int TS = 4;

  logic clk = 1'b0;
  logic rst_n, flush, in_valid, out_ready;
  logic signed [FW-1:0] in_fitness;
  logic [IW-1:0] in_index;

  logic in_ready_mn, out_valid_mn, busy_mn;
  logic [IW-1:0] out_index_mn;
  logic signed [FW-1:0] out_fitness_mn;
  logic in_ready_mx, out_valid_mx, busy_mx;
  logic [IW-1:0] out_index_mx;
  logic signed [FW-1:0] out_fitness_mx;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tournament_selection #(.FIT_W(FW), .IDX_W(IW), .TOUR_SIZE(TS), .MAXIMIZE(1'b0)) u_min (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_mn),
    .in_fitness(in_fitness), .in_index(in_index), .out_valid(out_valid_mn),
    .out_ready(out_ready), .out_index(out_index_mn), .out_fitness(out_fitness_mn),
    .busy(busy_mn));

  tournament_selection #(.FIT_W(FW), .IDX_W(IW), .TOUR_SIZE(TS), .MAXIMIZE(1'b1)) u_max (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_mx),
    .in_fitness(in_fitness), .in_index(in_index), .out_valid(out_valid_mx),
    .out_ready(out_ready), .out_index(out_index_mx), .out_fitness(out_fitness_mx),
    .busy(busy_mx));

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the current tournament is a list of candidates; the winner
  // is the extreme fitness value, taken at its last occurrence.
  logic signed [FW-1:0] q_fit[$];
  logic [IW-1:0]        q_idx[$];
  bit                   m_result = 1'b0;
  bit                   m_started = 1'b0;
  logic signed [FW-1:0] w_min_fit, w_max_fit;
  logic [IW-1:0]        w_min_idx, w_max_idx;

  always @(posedge clk) begin
    m_started = 1'b1;
    if (!rst_n || flush) begin
      q_fit.delete();
      q_idx.delete();
      m_result = 1'b0;
    end else if (!m_result) begin
      if (in_valid) begin
        q_fit.push_back(in_fitness);
        q_idx.push_back(in_index);
        if (q_fit.size() == TS) begin
          w_min_fit = q_fit[0];
          w_max_fit = q_fit[0];
          foreach (q_fit[i]) begin
            if (q_fit[i] < w_min_fit) w_min_fit = q_fit[i];
            if (q_fit[i] > w_max_fit) w_max_fit = q_fit[i];
          end
          foreach (q_fit[i]) begin
            if (q_fit[i] == w_min_fit) w_min_idx = q_idx[i];
            if (q_fit[i] == w_max_fit) w_max_idx = q_idx[i];
          end
          q_fit.delete();
          q_idx.delete();
          m_result = 1'b1;
        end
      end
    end else if (out_ready) begin
      m_result = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      check("in_ready_min", in_ready_mn, !m_result && rst_n);
      check("in_ready_max", in_ready_mx, !m_result && rst_n);
      check("out_valid_min", out_valid_mn, m_result);
      check("out_valid_max", out_valid_mx, m_result);
      check("busy_min", busy_mn, m_result || (q_fit.size() != 0));
      check("busy_max", busy_mx, m_result || (q_fit.size() != 0));
      if (m_result) begin
        check("model_index_min", out_index_mn, w_min_idx);
        check("model_fitness_min", out_fitness_mn, w_min_fit);
        check("model_index_max", out_index_mx, w_max_idx);
        check("model_fitness_max", out_fitness_mx, w_max_fit);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [FW-1:0] f, input logic [IW-1:0] i);
    int guard = 0;
    in_valid   = 1'b1;
    in_fitness = f;
    in_index   = i;
    while (!in_ready_mn && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) check("send_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_ready();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_fitness = 27'sd99; in_index = 8'd99;

    // Reset held with in_valid asserted.
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_out_valid", out_valid_mn, 0);
      check("rst_busy", busy_mn, 0);
      check("rst_in_ready", in_ready_mn, 0);
    end
    check("rst_fitness", out_fitness_mn, 0);
    check("rst_index", out_index_mn, 0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready_mn, 1);
    tick();

    // Minimise, back to back.
    send(27'sd50, 8'd10); send(-27'sd7, 8'd11); send(27'sd12, 8'd12); send(27'sd3, 8'd13);
    check("min_out_valid", out_valid_mn, 1);
    check("min_out_index", out_index_mn, 11);
    check("min_out_fitness", out_fitness_mn, -7);
    pulse_ready();
    check("min_back_collect", in_ready_mn, 1);

    // Ties with backpressure.
    send(27'sd5, 8'd1); send(27'sd5, 8'd2); send(27'sd9, 8'd3); send(27'sd5, 8'd4);
    for (int c = 0; c < 5; c++) begin
      check("tie_index_min", out_index_mn, 4);
      check("tie_fitness_min", out_fitness_mn, 5);
      check("tie_index_max", out_index_mx, 3);
      check("tie_in_ready", in_ready_mn, 0);
      tick();
    end
    pulse_ready();
    check("tie_collect", out_valid_mn, 0);
    check("tie_collect_ready", in_ready_mn, 1);

    // Signed extremes.
    send(-27'sd67108864, 8'd0); send(27'sd67108863, 8'd1); send(27'sd0, 8'd2); send(-27'sd1, 8'd3);
    check("ext_max_index", out_index_mx, 1);
    check("ext_max_fitness", out_fitness_mx, 67108863);
    check("ext_min_index", out_index_mn, 0);
    check("ext_min_fitness", out_fitness_mn, -67108864);
    pulse_ready();

    // Flush mid-tournament with a candidate presented.
    send(27'sd1, 8'd30); send(27'sd2, 8'd31);
    in_valid = 1'b1; in_fitness = -27'sd100; in_index = 8'd32; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_busy", busy_mn, 0);
    check("flush_in_ready", in_ready_mn, 1);
    send(27'sd7, 8'd20); send(27'sd8, 8'd21); send(27'sd9, 8'd22); send(27'sd6, 8'd23);
    check("flush_next_index", out_index_mn, 23);
    check("flush_next_valid", out_valid_mn, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_result_valid", out_valid_mn, 0);
    check("flush_result_busy", busy_mn, 0);

    // Randomised gapped tournaments.
    for (int t = 0; t < 1000; t++) begin
      bit eager = ($urandom_range(0, 1) == 1);
      out_ready = eager;
      for (int k = 0; k < TS; k++) begin
        int gap = $urandom_range(0, 3);
        logic signed [FW-1:0] f;
        for (int g = 0; g < gap; g++) tick();
        if ($urandom_range(0, 1) == 1) f = FW'($signed($urandom_range(0, 8)) - 4);
        else f = FW'($urandom);
        send(f, IW'($urandom));
      end
      if (!eager) begin
        int hold = $urandom_range(0, 3);
        for (int h = 0; h < hold; h++) tick();
        pulse_ready();
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
